// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, instruction decode with register file, load-use stall and flush into ID/EX.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] InstrIn,
  input  logic [31:0] PCPlus4In,
  input  logic        FetchValid,
  input  logic        Flush,
  input  logic        WbEn,
  input  logic [4:0]  WbAddr,
  input  logic [31:0] WbData,
  output logic        Stall,
  output logic        ExValid,
  output logic [31:0] ExPCPlus4,
  output logic [31:0] ExRsData,
  output logic [31:0] ExRtData,
  output logic [31:0] ExImm,
  output logic [4:0]  ExRs,
  output logic [4:0]  ExRt,
  output logic [4:0]  ExRd,
  output logic [1:0]  ExALUOp,
  output logic        ExRegDst,
  output logic        ExALUSrc,
  output logic        ExMemRead,
  output logic        ExMemWrite,
  output logic        ExMemToReg,
  output logic        ExRegWrite,
  output logic        ExBranch
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  alu_op;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        branch;
  } ex_t;
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  ex_t         ex_q, ex_d;
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        is_r, is_lw, is_sw, is_beq, is_addi, wb_we, bubble;
  logic [31:0] rs_data, rt_data;
  assign op      = instr_q[31:26];
  assign rs      = instr_q[25:21];
  assign rt      = instr_q[20:16];
  assign is_r    = op == 6'h00;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2b;
  assign is_beq  = op == 6'h04;
  assign is_addi = op == 6'h08;
  assign wb_we   = WbEn && WbAddr != 5'd0;
  // Write-back is forwarded so a value written this cycle is seen by the decode in the same cycle.
  assign rs_data = (rs == 5'd0) ? 32'd0 : (wb_we && WbAddr == rs) ? WbData : regs_q[rs];
  assign rt_data = (rt == 5'd0) ? 32'd0 : (wb_we && WbAddr == rt) ? WbData : regs_q[rt];
  // Load-use hazard: rt only counts as a source for R-type, sw and beq.
  assign Stall = valid_q && ex_q.valid && ex_q.mem_read && ex_q.rt != 5'd0 &&
                 (ex_q.rt == rs || (ex_q.rt == rt && (is_r || is_sw || is_beq)));
  assign bubble  = Flush || Stall || !valid_q;
  assign instr_d = Flush ? NOP_INSTR : Stall ? instr_q : InstrIn;
  assign pc_d    = Flush ? 32'd0 : Stall ? pc_q : PCPlus4In;
  assign valid_d = !Flush && (Stall ? valid_q : FetchValid);
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid      = 1'b1;
      ex_d.pc_plus4   = pc_q;
      ex_d.rs_data    = rs_data;
      ex_d.rt_data    = rt_data;
      ex_d.imm        = {{16{instr_q[15]}}, instr_q[15:0]};
      ex_d.rs         = rs;
      ex_d.rt         = rt;
      ex_d.rd         = instr_q[15:11];
      ex_d.alu_op     = {is_r, is_beq};
      ex_d.reg_dst    = is_r;
      ex_d.alu_src    = is_lw || is_sw || is_addi;
      ex_d.mem_read   = is_lw;
      ex_d.mem_write  = is_sw;
      ex_d.mem_to_reg = is_lw;
      ex_d.reg_write  = is_r || is_lw || is_addi;
      ex_d.branch     = is_beq;
    end
  end
  always_comb begin
    regs_d = regs_q;
    if (wb_we) regs_d[WbAddr] = WbData;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      ex_q    <= '0;
      regs_q  <= '{default: '0};
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ex_q    <= ex_d;
      regs_q  <= regs_d;
    end
  end
  assign ExValid    = ex_q.valid;
  assign ExPCPlus4  = ex_q.pc_plus4;
  assign ExRsData   = ex_q.rs_data;
  assign ExRtData   = ex_q.rt_data;
  assign ExImm      = ex_q.imm;
  assign ExRs       = ex_q.rs;
  assign ExRt       = ex_q.rt;
  assign ExRd       = ex_q.rd;
  assign ExALUOp    = ex_q.alu_op;
  assign ExRegDst   = ex_q.reg_dst;
  assign ExALUSrc   = ex_q.alu_src;
  assign ExMemRead  = ex_q.mem_read;
  assign ExMemWrite = ex_q.mem_write;
  assign ExMemToReg = ex_q.mem_to_reg;
  assign ExRegWrite = ex_q.reg_write;
  assign ExBranch   = ex_q.branch;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word loaded into IF/ID on reset or flush.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port InstrIn  input  32  instruction word from fetch stage.
REQ-005 SHALL have port PCPlus4In  input  32  PC+4 of InstrIn.
REQ-006 SHALL have port FetchValid  input  1  InstrIn is a real instruction.
REQ-007 SHALL have port Flush  input  1  taken branch; kill younger instructions.
REQ-008 SHALL have ports WbEn (input, 1), WbAddr (input, 5) and WbData (input, 32), together forming the register-file write-back port.
REQ-009 SHALL have port Stall  output  1  hold PC and fetch output this cycle.
REQ-010 SHALL have ID/EX register outputs with these widths: ExValid 1; ExPCPlus4 32; ExRsData 32; ExRtData 32; ExImm 32; ExRs 5; ExRt 5; ExRd 5; ExALUOp 2.
REQ-011 SHALL have ID/EX control outputs, each 1 bit: ExRegDst, ExALUSrc, ExMemRead, ExMemWrite, ExMemToReg, ExRegWrite, ExBranch.

Function
REQ-012 SHALL hold an IF/ID register (instr, pc+4, valid); on posedge it loads the inputs when Stall=0 and holds when Stall=1.
REQ-013 SHALL decode IF/ID instr into the ID/EX register every posedge, giving 1-cycle latency from IF/ID to Ex* outputs.
REQ-014 SHALL decode opcodes as follows:
- 000000 (R-type): RegDst=1, RegWrite=1, ALUOp=10.
- 100011 (lw): ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1, ALUOp=00.
- 101011 (sw): ALUSrc=1, MemWrite=1, ALUOp=00.
- 000100 (beq): Branch=1, ALUOp=01.
- 001000 (addi): ALUSrc=1, RegWrite=1, ALUOp=00.
- Any other opcode: all controls 0.
REQ-015 SHALL force all controls to 0 whenever the IF/ID valid bit is 0.
REQ-016 SHALL drive ExImm as instr[15:0] sign-extended to 32 bits, ExRs=instr[25:21], ExRt=instr[20:16], ExRd=instr[15:11].
REQ-017 SHALL contain a 32x32 register file with two combinational read ports and one write port; a write occurs at posedge when WbEn=1 and WbAddr!=0.
REQ-018 SHALL return 0 for reads of register 0 regardless of writes.
REQ-019 SHALL bypass write-back on reads: if WbEn=1, WbAddr!=0 and WbAddr equals the read address, the read returns WbData in the same cycle.
REQ-020 SHALL compute Stall combinationally as 1 when all of the following hold:
- IF/ID valid=1, ExValid=1, ExMemRead=1, ExRt!=0;
- and either ExRt==rs, or ExRt==rt with the IF/ID opcode being R-type, sw or beq.
REQ-021 SHALL, on a posedge with Stall=1 and Flush=0, keep IF/ID unchanged and load a bubble into ID/EX (ExValid=0, all controls 0).
REQ-022 SHALL, on a posedge with Flush=1, load IF/ID with NOP_INSTR/valid=0 and ID/EX with a bubble; Flush takes priority over Stall.
REQ-023 SHALL keep data fields of a bubble at 0.
REQ-024 SHALL drop FetchValid=0 instructions in place as bubbles, without stall.

Reset
REQ-025 SHALL, while Rst_n=0, asynchronously clear the following and hold them cleared until Rst_n rises:
- IF/ID to NOP_INSTR, pc+4=0, valid=0;
- all ID/EX outputs to 0;
- all 32 registers to 0.
REQ-026 SHALL drive Stall=0 during reset and in the first cycle after reset.
REQ-027 SHALL take effect immediately on reset assertion mid-operation, including during an active stall or an in-flight write-back; that write is discarded.

Verification
REQ-028 SHALL pass: write $17=35, $18=12 via WB, then InstrIn=0x02324020 (add $8,$17,$18), FetchValid=1 -> two edges later ExRsData=35, ExRtData=12, ExRd=8, ExRegDst=1, ExRegWrite=1, ExALUOp=10, ExValid=1.
REQ-029 SHALL pass: lw $16,0($8) (0x8D100000) then add $9,$16,$17 -> Stall=1 for exactly one cycle and one ID/EX bubble (ExValid=0); the add issues on the next edge with ExRs=16.
REQ-030 SHALL pass: WbEn=1, WbAddr=17, WbData=0x55 in the same cycle IF/ID holds rs=17 -> ExRsData=0x55; WbEn=1, WbAddr=0, WbData=0xFF -> later reads of $0 return 0.
REQ-031 SHALL pass: Flush=1 in a cycle where Stall=1 -> next edge ExValid=0, IF/ID valid=0, Stall=0.
REQ-032 SHALL pass: addi $8,$0,-4 (0x2008FFFC) -> ExImm=0xFFFFFFFC, ExALUSrc=1, ExRegWrite=1, ExRegDst=0.
REQ-033 SHALL pass: Rst_n pulsed low mid-stream between edges -> all Ex* outputs and Stall read 0 immediately, and a previously written $17 reads 0 afterwards.
